// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// APB initiator. A core-side request port, which allows one outstanding
// request at a time, is bridged onto an APB bus with NUM_SLAVES one-hot
// select lines. The request address is decoded into a slave index, the APB
// SETUP/ACCESS sequence is run, and completion comes back as a single-cycle
// ready pulse carrying read data and an error flag.
//
// Handshake: transfer is sampled only while the FSM is IDLE (busy=0). A
// request is accepted on the rising PCLK edge where IDLE && transfer. Its
// completion is signalled by exactly one cycle of ready=1. err and rdata are
// meaningful only in that cycle. Requests raised while busy are dropped, not
// queued. ready is returned in an IDLE cycle, so a transfer held high in that
// cycle is accepted immediately (back-to-back operation).
//
// Ports
//   PCLK, PRESET      clock; asynchronous active-high reset
//   transfer          request strobe (sampled in IDLE only)
//   write             1 = write, 0 = read
//   addr, wdata       request byte address and write data
//   rdata             read data, valid while ready=1
//   ready             one-cycle completion pulse
//   err               with ready: decode miss or PREADY timeout
//   busy              high while in SETUP or ACCESS
//   PADDR, PWRITE,
//   PWDATA, PENABLE,
//   PSEL              APB master outputs (PSEL one-hot)
//   PRDATA, PREADY    packed per-slave read data / ready (slave i at slice i)
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] ADDR_BASE  = 32'h1000_0000,
    parameter int          SLAVE_SPAN = 12,
    parameter int          TIMEOUT    = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     transfer,
    input  logic                     write,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     ready,
    output logic                     err,
    output logic                     busy,
    output logic [31:0]              PADDR,
    output logic                     PWRITE,
    output logic                     PENABLE,
    output logic [31:0]              PWDATA,
    output logic [NUM_SLAVES-1:0]    PSEL,
    input  logic [32*NUM_SLAVES-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY
);

    localparam int IDXW = $clog2(NUM_SLAVES);
    // Bits at and above DEC_LO select the peripheral region; the IDXW bits
    // just below select the slave inside it.
    localparam int DEC_LO = SLAVE_SPAN + IDXW;
    localparam int CW     = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IDXW-1:0]     sel_idx;
    logic [CW-1:0]       wait_cnt;
    logic                hit;
    logic                sel_ready;
    logic [31:0]         sel_rdata;
    logic [NUM_SLAVES-1:0] sel_onehot;
    logic                timed_out;

    assign hit = (addr >> DEC_LO) == (ADDR_BASE >> DEC_LO);

    // Only the latched slave's PREADY/PRDATA are ever looked at.
    always_comb begin
        sel_ready  = 1'b0;
        sel_rdata  = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_idx == IDXW'(i)) begin
                sel_ready     = PREADY[i];
                sel_rdata     = PRDATA[32*i +: 32];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // wait_cnt holds the number of completed ACCESS cycles without PREADY,
    // so the TIMEOUT-th ACCESS cycle is the one where it reads TIMEOUT-1.
    assign timed_out = (state == ST_ACCESS) && !sel_ready &&
                       (wait_cnt == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and bus control. PSEL/PENABLE/busy decode straight from the
    // state register so an asynchronous reset clears them without waiting
    // for a clock edge.
    always_comb begin
        state_next = state;
        PSEL       = '0;
        PENABLE    = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (transfer && hit) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                busy       = 1'b1;
                PSEL       = sel_onehot;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                busy    = 1'b1;
                PSEL    = sel_onehot;
                PENABLE = 1'b1;
                if (sel_ready || timed_out) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, wait counter and completion response
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR    <= '0;
            PWDATA   <= '0;
            PWRITE   <= 1'b0;
            sel_idx  <= '0;
            wait_cnt <= '0;
            rdata    <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        if (hit) begin
                            PADDR   <= addr;
                            PWDATA  <= wdata;
                            PWRITE  <= write;
                            sel_idx <= addr[SLAVE_SPAN +: IDXW];
                        end else begin
                            // Decode miss: answer locally, bus untouched.
                            ready <= 1'b1;
                            err   <= 1'b1;
                            rdata <= '0;
                        end
                    end
                end
                ST_SETUP: begin
                    wait_cnt <= '0;
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        ready <= 1'b1;
                        if (!PWRITE) begin
                            rdata <= sel_rdata;
                        end
                    end else if (timed_out) begin
                        ready <= 1'b1;
                        err   <= 1'b1;
                        rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Self-checking bench for apb_master_bridge. A behavioural APB slave array
// (register per slave, programmable wait states, optional stuck-high PREADY)
// sits on the bus. Expected results come from a transaction-level model:
// address range -> hit/index, wait count -> latency/timeout, and a copy of
// slave contents and of the last returned read data.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int          NUM  = 4;
    localparam int          TO   = 16;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          WIN  = 4096;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              transfer;
    logic              write;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic              err;
    logic              busy;
    logic [31:0]       PADDR;
    logic              PWRITE;
    logic              PENABLE;
    logic [31:0]       PWDATA;
    logic [NUM-1:0]    PSEL;
    logic [32*NUM-1:0] PRDATA;
    logic [NUM-1:0]    PREADY;

    int checks = 0;
    int errors = 0;

    apb_master_bridge #(
        .NUM_SLAVES(NUM),
        .ADDR_BASE (BASE),
        .SLAVE_SPAN(12),
        .TIMEOUT   (TO)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .transfer(transfer),
        .write   (write),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .err     (err),
        .busy    (busy),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PWDATA  (PWDATA),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    // ---------------- clock ----------------
    always #5 PCLK = ~PCLK;

    // ---------------- behavioural APB slaves ----------------
    logic [31:0] slave_mem [NUM];
    int          acc_cnt   [NUM];
    int          wait_cfg  [NUM];
    logic        stuck_ready [NUM];
    logic        pl_en;
    int          pl_idx;
    logic [31:0] pl_val;

    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            PRDATA[32*i +: 32] = slave_mem[i];
            PREADY[i] = stuck_ready[i] ||
                        (PSEL[i] && PENABLE && (acc_cnt[i] >= wait_cfg[i]));
        end
    end

    always @(posedge PCLK) begin
        for (int i = 0; i < NUM; i++) begin
            if (PSEL[i] && PENABLE) begin
                if (PREADY[i]) begin
                    acc_cnt[i] <= 0;
                    if (PWRITE) slave_mem[i] <= PWDATA;
                end else begin
                    acc_cnt[i] <= acc_cnt[i] + 1;
                end
            end else begin
                acc_cnt[i] <= 0;
            end
        end
        if (pl_en) slave_mem[pl_idx] <= pl_val;
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_mem [NUM];
    logic [31:0] exp_rdata;

    function automatic int addr_idx(input logic [31:0] a);
        return int'((a - BASE) / WIN);
    endfunction

    function automatic logic addr_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(NUM * WIN));
    endfunction

    // Predicts one transaction and advances the model state.
    function automatic void model_xfer(input logic w, input logic [31:0] a,
                                       input logic [31:0] d, input int wt,
                                       output int lat, output logic [31:0] rd,
                                       output logic e, output int en,
                                       output logic [NUM-1:0] sel);
        int ix;
        if (!addr_hit(a)) begin
            lat = 1; e = 1'b1; en = 0; sel = '0;
            exp_rdata = 32'h0;
        end else begin
            ix  = addr_idx(a);
            sel = NUM'(1) << ix;
            if (wt >= TO) begin
                lat = 2 + TO; e = 1'b1; en = TO;
                exp_rdata = 32'h0;
            end else begin
                lat = 3 + wt; e = 1'b0; en = 1 + wt;
                if (w) exp_mem[ix] = d;
                else   exp_rdata = exp_mem[ix];
            end
        end
        rd = exp_rdata;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic preload(input int i, input logic [31:0] v);
        @(negedge PCLK);
        pl_en = 1'b1; pl_idx = i; pl_val = v;
        @(negedge PCLK);
        pl_en = 1'b0;
        exp_mem[i] = v;
    endtask

    // Issues one request and observes the bus until ready (or budget runs out).
    task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input int budget, output int lat, output logic [31:0] rd,
                            output logic e, output int en, output logic [NUM-1:0] sel,
                            output logic stable);
        @(negedge PCLK);
        transfer = 1'b1; write = w; addr = a; wdata = d;
        @(posedge PCLK);
        #1 transfer = 1'b0;
        lat = -1; rd = '0; e = 1'b0; en = 0; sel = '0; stable = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge PCLK);
            if (PENABLE) en++;
            sel |= PSEL;
            if (busy && (PADDR !== a || PWRITE !== w || (w && PWDATA !== d)))
                stable = 1'b0;
            if (ready) begin
                lat = c; rd = rdata; e = err;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0; pl_en = 1'b0;
        pl_idx = 0; pl_val = '0;
        for (int i = 0; i < NUM; i++) begin
            wait_cfg[i] = 0; stuck_ready[i] = 1'b0;
            slave_mem[i] = '0; exp_mem[i] = '0; acc_cnt[i] = 0;
        end
        exp_rdata = '0;
        repeat (3) @(negedge PCLK);
        checks++; if (PSEL !== '0 || PENABLE !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_bus PSEL=%b PENABLE=%b busy=%b exp 0", PSEL, PENABLE, busy);
        end
        checks++; if (PADDR !== '0 || PWDATA !== '0 || PWRITE !== 1'b0) begin
            errors++; $display("FAIL reset_regs PADDR=%h PWDATA=%h PWRITE=%b exp 0", PADDR, PWDATA, PWRITE);
        end
        checks++; if (rdata !== '0 || ready !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_resp rdata=%h ready=%b err=%b exp 0", rdata, ready, err);
        end
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
    endtask

    task automatic test_write_wait;
        int lat, en, xl, xen; logic [31:0] rd, xrd; logic e, xe, st; logic [NUM-1:0] sel, xsel;
        wait_cfg[1] = 1;
        model_xfer(1'b1, 32'h1000_1004, 32'h0000_04D2, 1, xl, xrd, xe, xen, xsel);
        run_xfer(1'b1, 32'h1000_1004, 32'h0000_04D2, 30, lat, rd, e, en, sel, st);
        checks++; if (lat !== xl || e !== xe) begin
            errors++; $display("FAIL wr_wait_done lat=%0d err=%b exp lat=%0d err=%b", lat, e, xl, xe);
        end
        checks++; if (en !== xen || sel !== xsel || !st) begin
            errors++; $display("FAIL wr_wait_bus en=%0d sel=%b stable=%b exp en=%0d sel=%b stable=1", en, sel, st, xen, xsel);
        end
        checks++; if (slave_mem[1] !== exp_mem[1]) begin
            errors++; $display("FAIL wr_wait_data got %h exp %h", slave_mem[1], exp_mem[1]);
        end
        wait_cfg[1] = 0;
    endtask

    task automatic test_read;
        int lat, en, xl, xen; logic [31:0] rd, xrd; logic e, xe, st; logic [NUM-1:0] sel, xsel;
        preload(0, 32'hFFFF_FFFF);
        preload(1, 32'h0000_0001);
        model_xfer(1'b0, 32'h1000_1000, 32'h0, 0, xl, xrd, xe, xen, xsel);
        run_xfer(1'b0, 32'h1000_1000, 32'h0, 30, lat, rd, e, en, sel, st);
        checks++; if (lat !== xl || e !== xe || rd !== xrd) begin
            errors++; $display("FAIL rd_zero_wait lat=%0d err=%b rdata=%h exp lat=%0d err=%b rdata=%h", lat, e, rd, xl, xe, xrd);
        end
        checks++; if (sel !== xsel || en !== xen || !st) begin
            errors++; $display("FAIL rd_bus sel=%b en=%0d stable=%b exp sel=%b en=%0d stable=1", sel, en, st, xsel, xen);
        end
    endtask

    task automatic test_decode_miss;
        int lat, en, xl, xen; logic [31:0] rd, xrd; logic e, xe, st; logic [NUM-1:0] sel, xsel;
        model_xfer(1'b0, 32'h2000_0000, 32'h0, 0, xl, xrd, xe, xen, xsel);
        run_xfer(1'b0, 32'h2000_0000, 32'h0, 10, lat, rd, e, en, sel, st);
        checks++; if (lat !== xl || e !== xe || rd !== xrd) begin
            errors++; $display("FAIL miss_resp lat=%0d err=%b rdata=%h exp lat=%0d err=%b rdata=%h", lat, e, rd, xl, xe, xrd);
        end
        checks++; if (sel !== xsel || en !== xen) begin
            errors++; $display("FAIL miss_bus sel=%b en=%0d exp sel=%b en=%0d", sel, en, xsel, xen);
        end
        @(negedge PCLK);
        checks++; if (ready !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL miss_pulse ready=%b err=%b exp 0 0", ready, err);
        end
    endtask

    task automatic test_timeout;
        int lat, en, xl, xen; logic [31:0] rd, xrd; logic e, xe, st; logic [NUM-1:0] sel, xsel;
        // Leave nonzero rdata behind so the abort clearing it is visible.
        preload(2, 32'hA5A5_0F0F);
        model_xfer(1'b0, 32'h1000_2000, 32'h0, 0, xl, xrd, xe, xen, xsel);
        run_xfer(1'b0, 32'h1000_2000, 32'h0, 30, lat, rd, e, en, sel, st);
        checks++; if (rd !== xrd || lat !== xl) begin
            errors++; $display("FAIL to_preread rdata=%h lat=%0d exp %h %0d", rd, lat, xrd, xl);
        end
        wait_cfg[3] = 1000;
        stuck_ready[0] = 1'b1;  // unselected slave shouting ready must be ignored
        model_xfer(1'b0, 32'h1000_3000, 32'h0, 1000, xl, xrd, xe, xen, xsel);
        run_xfer(1'b0, 32'h1000_3000, 32'h0, 40, lat, rd, e, en, sel, st);
        checks++; if (lat !== xl || e !== xe || rd !== xrd) begin
            errors++; $display("FAIL timeout_resp lat=%0d err=%b rdata=%h exp lat=%0d err=%b rdata=%h", lat, e, rd, xl, xe, xrd);
        end
        checks++; if (en !== xen || sel !== xsel) begin
            errors++; $display("FAIL timeout_bus en=%0d sel=%b exp en=%0d sel=%b", en, sel, xen, xsel);
        end
        checks++; if (busy !== 1'b0 || PSEL !== '0) begin
            errors++; $display("FAIL timeout_idle busy=%b PSEL=%b exp 0", busy, PSEL);
        end
        model_xfer(1'b1, 32'h1000_0010, 32'h1357_2468, 0, xl, xrd, xe, xen, xsel);
        run_xfer(1'b1, 32'h1000_0010, 32'h1357_2468, 30, lat, rd, e, en, sel, st);
        checks++; if (lat !== xl || e !== xe || slave_mem[0] !== exp_mem[0]) begin
            errors++; $display("FAIL timeout_recover lat=%0d err=%b mem=%h exp lat=%0d err=%b mem=%h", lat, e, slave_mem[0], xl, xe, exp_mem[0]);
        end
        wait_cfg[3] = 0;
        stuck_ready[0] = 1'b0;
    endtask

    task automatic test_back_to_back;
        int rdy_q[$], set_q[$], exp_rdy_q[$], exp_set_q[$];
        logic [31:0] v;
        v = $urandom;
        preload(2, v);
        // Each zero-wait transaction spans 3 cycles and the next SETUP
        // follows its ready cycle directly.
        for (int k = 0; k < 4; k++) begin
            exp_set_q.push_back(3 * k + 1);
            exp_rdy_q.push_back(3 * k + 3);
        end
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_2000; wdata = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge PCLK);
            if (busy && !PENABLE) set_q.push_back(c);
            if (ready) begin
                rdy_q.push_back(c);
                checks++; if (rdata !== exp_mem[2] || err !== 1'b0) begin
                    errors++; $display("FAIL b2b_data cyc=%0d rdata=%h err=%b exp %h 0", c, rdata, err, exp_mem[2]);
                end
            end
            if (c == 12) transfer = 1'b0;
        end
        exp_rdata = exp_mem[2];
        checks++; if (rdy_q != exp_rdy_q) begin
            errors++; $display("FAIL b2b_ready count=%0d exp count=%0d", rdy_q.size(), exp_rdy_q.size());
        end
        checks++; if (set_q != exp_set_q) begin
            errors++; $display("FAIL b2b_setup count=%0d exp count=%0d", set_q.size(), exp_set_q.size());
        end
        repeat (2) @(negedge PCLK);
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle busy=%b exp 0", busy);
        end
    endtask

    task automatic test_random;
        int lat, en, xl, xen, wt, ix; logic [31:0] rd, xrd, a, d; logic e, xe, st, w;
        logic [NUM-1:0] sel, xsel;
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            ix = $urandom_range(0, NUM - 1);
            if ($urandom_range(0, 5) == 0) begin
                a = $urandom;
                if (addr_hit(a)) a[31] = ~a[31];
            end else begin
                a = BASE + 32'(ix * WIN) + 32'($urandom_range(0, 1023) * 4);
            end
            wt = ($urandom_range(0, 7) == 0) ? TO + 3 : $urandom_range(0, 3);
            wait_cfg[ix] = wt;
            model_xfer(w, a, d, wt, xl, xrd, xe, xen, xsel);
            run_xfer(w, a, d, TO + 8, lat, rd, e, en, sel, st);
            checks++; if (lat !== xl || e !== xe || rd !== xrd) begin
                errors++; $display("FAIL rand_resp n=%0d a=%h w=%b lat=%0d err=%b rdata=%h exp lat=%0d err=%b rdata=%h",
                                   n, a, w, lat, e, rd, xl, xe, xrd);
            end
            checks++; if (sel !== xsel || en !== xen || !st) begin
                errors++; $display("FAIL rand_bus n=%0d sel=%b en=%0d stable=%b exp sel=%b en=%0d stable=1", n, sel, en, st, xsel, xen);
            end
            checks++; if (slave_mem[ix] !== exp_mem[ix]) begin
                errors++; $display("FAIL rand_mem n=%0d slave=%0d got %h exp %h", n, ix, slave_mem[ix], exp_mem[ix]);
            end
        end
        for (int i = 0; i < NUM; i++) wait_cfg[i] = 0;
    endtask

    task automatic test_reset_mid;
        int lat, en, xl, xen, seen_ready; logic [31:0] rd, xrd; logic e, xe, st, got_en;
        logic [NUM-1:0] sel, xsel;
        preload(1, 32'hCAFE_0001);
        model_xfer(1'b0, 32'h1000_1000, 32'h0, 0, xl, xrd, xe, xen, xsel);
        run_xfer(1'b0, 32'h1000_1000, 32'h0, 30, lat, rd, e, en, sel, st);
        checks++; if (rdata !== xrd) begin
            errors++; $display("FAIL rst_preread rdata=%h exp %h", rdata, xrd);
        end
        wait_cfg[1] = 5;
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000;
        @(posedge PCLK);
        #1 transfer = 1'b0;
        got_en = 1'b0;
        for (int c = 0; c < 10 && !got_en; c++) begin
            @(negedge PCLK);
            got_en = PENABLE;
        end
        checks++; if (!got_en) begin
            errors++; $display("FAIL rst_access PENABLE=0 exp 1 within 10 cycles");
        end
        #2 PRESET = 1'b1;
        #1;
        checks++; if (PSEL !== '0 || PENABLE !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_async PSEL=%b PENABLE=%b busy=%b exp 0", PSEL, PENABLE, busy);
        end
        exp_rdata = '0;
        seen_ready = 0;
        repeat (3) begin
            @(negedge PCLK);
            if (ready) seen_ready++;
        end
        PRESET = 1'b0;
        repeat (6) begin
            @(negedge PCLK);
            if (ready || busy) seen_ready++;
        end
        checks++; if (seen_ready !== 0 || rdata !== exp_rdata) begin
            errors++; $display("FAIL rst_no_pulse stray=%0d rdata=%h exp 0 %h", seen_ready, rdata, exp_rdata);
        end
        wait_cfg[1] = 0;
        model_xfer(1'b1, 32'h1000_0000, 32'h8765_4321, 0, xl, xrd, xe, xen, xsel);
        run_xfer(1'b1, 32'h1000_0000, 32'h8765_4321, 30, lat, rd, e, en, sel, st);
        checks++; if (lat !== xl || e !== xe || slave_mem[0] !== exp_mem[0] || sel !== xsel) begin
            errors++; $display("FAIL rst_recover lat=%0d err=%b mem=%h sel=%b exp lat=%0d err=%b mem=%h sel=%b",
                               lat, e, slave_mem[0], sel, xl, xe, exp_mem[0], xsel);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_wait();
        test_read();
        test_decode_miss();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
